// File: rtl/port_ring_tap_mc.sv
// rtl/port_ring_tap_mc.sv - multicast ring tap: strips own dvec bit, copies to ptx, forwards remainder, injects local rx
// Optional PORT_RING_TAP_RING_PRIO_EN: strict ring priority instead of round-robin at packet boundaries.
module port_ring_tap_mc #(
    parameter int pdp_sz    = 66,
    parameter int num_ports = 4,
    parameter int rdp_sz    = pdp_sz + num_ports,
    parameter int portnum   = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ri_srdy,
    output logic                 ri_drdy,
    input  logic [rdp_sz-1:0]    ri_data,
    input  logic                 prx_srdy,
    output logic                 prx_drdy,
    input  logic [pdp_sz-1:0]    prx_data,
    input  logic                 fli_srdy,
    output logic                 fli_drdy,
    input  logic [num_ports-1:0] fli_data,
    output logic                 ro_srdy,
    input  logic                 ro_drdy,
    output logic [rdp_sz-1:0]    ro_data,
    output logic                 ptx_srdy,
    input  logic                 ptx_drdy,
    output logic [pdp_sz-1:0]    ptx_data,
    output logic                 drop_err
);
    typedef enum logic [2:0] {IDLE, RING, LKUP, LOCAL, LDROP} state_t;

    localparam logic [num_ports-1:0] own = {{(num_ports-1){1'b0}}, 1'b1} << portnum;

    state_t                state;
    logic                  run;
    logic                  ri_v, px_v, fl_v, ro_v, tx_v;
    logic [rdp_sz-1:0]     ri_q, ro_q;
    logic [pdp_sz-1:0]     px_q, tx_q;
    logic [num_ports-1:0]  fl_q, m;
    logic                  c;
`ifndef PORT_RING_TAP_RING_PRIO_EN
    logic                  rr_ring;
`endif

    logic [1:0]            ri_pc, px_pc;
    logic [num_ports-1:0]  ri_dvec, m_eff;
    logic                  c_eff, ro_free, tx_free;
    logic                  ring_req, loc_req, grant_ring, grant_loc, ring_go;
    logic                  ri_pop, px_pop, fl_pop, ro_load, tx_load, drop_now;
    logic [rdp_sz-1:0]     ro_next;

    assign ri_pc   = ri_q[pdp_sz-1:pdp_sz-2];
    assign px_pc   = px_q[pdp_sz-1:pdp_sz-2];
    assign ri_dvec = ri_q[rdp_sz-1:pdp_sz];
    assign ro_free = !ro_v || ro_drdy;
    assign tx_free = !tx_v || ptx_drdy;

    // run gates the ready outputs so they read 0 while reset is held
    assign ri_drdy  = run && (!ri_v || ri_pop);
    assign prx_drdy = run && (!px_v || px_pop);
    assign fli_drdy = run && (!fl_v || fl_pop);
    assign ro_srdy  = ro_v;
    assign ro_data  = ro_q;
    assign ptx_srdy = tx_v;
    assign ptx_data = tx_q;

    always_comb begin
        ri_pop     = 1'b0;
        px_pop     = 1'b0;
        fl_pop     = 1'b0;
        ro_load    = 1'b0;
        tx_load    = 1'b0;
        drop_now   = 1'b0;
        ro_next    = '0;
        grant_ring = 1'b0;
        grant_loc  = 1'b0;
        ring_go    = 1'b0;
        m_eff      = m;
        c_eff      = c;
        ring_req   = ri_v && ri_pc[0];
        loc_req    = px_v && px_pc[0];
        case (state)
            IDLE: begin
                if (ri_v && !ri_pc[0]) begin
                    ri_pop   = 1'b1;
                    drop_now = 1'b1;
                end else if (px_v && !px_pc[0]) begin
                    px_pop   = 1'b1;
                    drop_now = 1'b1;
                end else begin
`ifdef PORT_RING_TAP_RING_PRIO_EN
                    grant_ring = ring_req;
                    grant_loc  = loc_req && !ring_req;
`else
                    grant_ring = ring_req && (!loc_req || rr_ring);
                    grant_loc  = loc_req && (!ring_req || !rr_ring);
`endif
                end
                if (grant_ring) begin
                    m_eff = ri_dvec & ~own;
                    c_eff = ri_dvec[portnum];
                end
            end
            LKUP:  fl_pop = fl_v;
            LOCAL: begin
                if (px_v && ro_free) begin
                    px_pop  = 1'b1;
                    ro_load = 1'b1;
                    ro_next = {m, px_q};
                end
            end
            LDROP: px_pop = px_v;
            default: ;
        endcase
        // ring SOP is forwarded in the grant cycle, keeping ri->ro at two cycles
        if (state == RING || grant_ring) begin
            ring_go = ri_v && (!c_eff || tx_free) && (m_eff == '0 || ro_free);
            if (ring_go) begin
                ri_pop  = 1'b1;
                tx_load = c_eff;
                ro_load = (m_eff != '0);
                ro_next = {m_eff, ri_q[pdp_sz-1:0]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            run      <= 1'b0;
            ri_v     <= 1'b0;
            px_v     <= 1'b0;
            fl_v     <= 1'b0;
            ro_v     <= 1'b0;
            tx_v     <= 1'b0;
            ri_q     <= '0;
            px_q     <= '0;
            fl_q     <= '0;
            ro_q     <= '0;
            tx_q     <= '0;
            m        <= '0;
            c        <= 1'b0;
            drop_err <= 1'b0;
`ifndef PORT_RING_TAP_RING_PRIO_EN
            rr_ring  <= 1'b1;
`endif
        end else begin
            run      <= 1'b1;
            drop_err <= drop_now;
            if (ri_srdy && ri_drdy) begin
                ri_v <= 1'b1;
                ri_q <= ri_data;
            end else if (ri_pop) begin
                ri_v <= 1'b0;
            end
            if (prx_srdy && prx_drdy) begin
                px_v <= 1'b1;
                px_q <= prx_data;
            end else if (px_pop) begin
                px_v <= 1'b0;
            end
            if (fli_srdy && fli_drdy) begin
                fl_v <= 1'b1;
                fl_q <= fli_data;
            end else if (fl_pop) begin
                fl_v <= 1'b0;
            end
            if (ro_load) begin
                ro_v <= 1'b1;
                ro_q <= ro_next;
            end else if (ro_drdy) begin
                ro_v <= 1'b0;
            end
            if (tx_load) begin
                tx_v <= 1'b1;
                tx_q <= ri_q[pdp_sz-1:0];
            end else if (ptx_drdy) begin
                tx_v <= 1'b0;
            end
`ifndef PORT_RING_TAP_RING_PRIO_EN
            if (grant_ring)
                rr_ring <= 1'b0;
            else if (grant_loc)
                rr_ring <= 1'b1;
`endif
            case (state)
                IDLE: begin
                    if (grant_ring) begin
                        m     <= m_eff;
                        c     <= c_eff;
                        state <= (ring_go && ri_pc[1]) ? IDLE : RING;
                    end else if (grant_loc) begin
                        state <= LKUP;
                    end
                end
                RING:  if (ring_go && ri_pc[1]) state <= IDLE;
                LKUP: begin
                    if (fl_v) begin
                        m     <= fl_q & ~own;
                        c     <= 1'b0;
                        state <= ((fl_q & ~own) != '0) ? LOCAL : LDROP;
                    end
                end
                LOCAL, LDROP: if (px_pop && px_pc[1]) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_port_ring_tap_mc.sv
// tb/tb_port_ring_tap_mc.sv - scoreboard bench for port_ring_tap_mc (portnum 0, 4 ports)
module tb_port_ring_tap_mc;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        ri_srdy, ri_drdy, prx_srdy, prx_drdy, fli_srdy, fli_drdy;
    logic        ro_srdy, ro_drdy, ptx_srdy, ptx_drdy, drop_err;
    logic [69:0] ri_data, ro_data;
    logic [65:0] prx_data, ptx_data;
    logic [3:0]  fli_data;

    port_ring_tap_mc dut (
        .clk(clk), .reset_n(reset_n),
        .ri_srdy(ri_srdy), .ri_drdy(ri_drdy), .ri_data(ri_data),
        .prx_srdy(prx_srdy), .prx_drdy(prx_drdy), .prx_data(prx_data),
        .fli_srdy(fli_srdy), .fli_drdy(fli_drdy), .fli_data(fli_data),
        .ro_srdy(ro_srdy), .ro_drdy(ro_drdy), .ro_data(ro_data),
        .ptx_srdy(ptx_srdy), .ptx_drdy(ptx_drdy), .ptx_data(ptx_data),
        .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ro_hs = 0;
    int          tx_hs = 0;
    int          drop_cnt = 0;
    int          first_ro_cyc = -1;
    int          ri_sop_cyc = 0;
    logic [69:0] exp_ro[$];
    logic [65:0] exp_tx[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timeout", nm);
    endtask

    // scoreboard monitor: pops expected words on every output handshake
    always @(negedge clk) begin
        if (reset_n) begin
            if (ro_srdy && first_ro_cyc < 0) first_ro_cyc = cyc;
            if (drop_err) drop_cnt++;
            if (ro_srdy && ro_drdy) begin
                ro_hs++;
                if (exp_ro.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ro_unexpected got=%h", ro_data);
                end else begin
                    check("ro_word", 128'(ro_data), 128'(exp_ro.pop_front()));
                end
            end
            if (ptx_srdy && ptx_drdy) begin
                tx_hs++;
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ptx_unexpected got=%h", ptx_data);
                end else begin
                    check("ptx_word", 128'(ptx_data), 128'(exp_tx.pop_front()));
                end
            end
        end
    end

    function automatic logic [1:0] pcode_of(input int i, input int n);
        if (n == 1) return 2'b11;
        if (i == 0) return 2'b01;
        if (i == n - 1) return 2'b10;
        return 2'b00;
    endfunction

    task automatic send_ri(input logic [69:0] w);
        int n;
        n = 0;
        ri_data = w;
        ri_srdy = 1'b1;
        @(negedge clk);
        while (!ri_drdy && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!ri_drdy) fail_now("ri_send");
        else if (w[64]) ri_sop_cyc = cyc;
        @(posedge clk);
        #1;
        ri_srdy = 1'b0;
    endtask

    task automatic send_px(input logic [65:0] w);
        int n;
        n = 0;
        prx_data = w;
        prx_srdy = 1'b1;
        @(negedge clk);
        while (!prx_drdy && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!prx_drdy) fail_now("prx_send");
        @(posedge clk);
        #1;
        prx_srdy = 1'b0;
    endtask

    task automatic send_fli(input logic [3:0] mask);
        int n;
        n = 0;
        fli_data = mask;
        fli_srdy = 1'b1;
        @(negedge clk);
        while (!fli_drdy && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!fli_drdy) fail_now("fli_send");
        @(posedge clk);
        #1;
        fli_srdy = 1'b0;
    endtask

    task automatic send_ri_pkt(input logic [3:0] dvec, input int n, input logic [63:0] base, input bit push);
        for (int i = 0; i < n; i++) begin
            logic [65:0] p;
            p = {pcode_of(i, n), base + 64'(i)};
            if (push) begin
                if (dvec[0]) exp_tx.push_back(p);
                if ((dvec & 4'b1110) != 4'b0000) exp_ro.push_back({dvec & 4'b1110, p});
            end
            send_ri({dvec, p});
        end
    endtask

    task automatic send_px_pkt(input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++) send_px({pcode_of(i, n), base + 64'(i)});
    endtask

    task automatic drain;
        int n;
        n = 0;
        while ((exp_ro.size() != 0 || exp_tx.size() != 0) && n < 300) begin
            n++;
            @(posedge clk);
        end
        if (exp_ro.size() != 0 || exp_tx.size() != 0) fail_now("drain");
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int snap_ro, snap_tx, snap_drop;
        reset_n  = 1'b0;
        ri_srdy  = 1'b0; ri_data  = '0;
        prx_srdy = 1'b0; prx_data = '0;
        fli_srdy = 1'b0; fli_data = '0;
        ro_drdy  = 1'b1; ptx_drdy = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_srdy", 128'({ro_srdy, ptx_srdy}), 128'(0));
        check("rst_drdy", 128'({ri_drdy, prx_drdy, fli_drdy}), 128'(0));
        check("rst_drop", 128'(drop_err), 128'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // unicast pass-through with latency check
        first_ro_cyc = -1;
        send_ri_pkt(4'b0100, 3, 64'h1000, 1'b1);
        drain();
        check("uni_latency", 128'(first_ro_cyc - ri_sop_cyc), 128'(2));

        // multicast with ptx stall: ro must stall in lockstep
        fork
            send_ri_pkt(4'b0101, 3, 64'h2000, 1'b1);
            begin
                ptx_drdy = 1'b0;
                snap_ro = ro_hs;
                repeat (5) @(posedge clk);
                #1;
                check("mc_stall_ro", 128'(ro_hs - snap_ro), 128'(1));
                ptx_drdy = 1'b1;
            end
        join
        drain();

        // terminal drop: copy to ptx only
        snap_ro = ro_hs;
        snap_tx = tx_hs;
        send_ri_pkt(4'b0001, 4, 64'h3000, 1'b1);
        drain();
        check("term_ro_none", 128'(ro_hs - snap_ro), 128'(0));
        check("term_tx_cnt", 128'(tx_hs - snap_tx), 128'(4));

        // local inject, then local-to-self drop
        exp_ro.push_back({4'b0010, 2'b11, 64'h4000});
        fork
            send_px({2'b11, 64'h4000});
            send_fli(4'b0011);
        join
        drain();
        snap_ro = ro_hs;
        snap_tx = tx_hs;
        fork
            send_px({2'b11, 64'h4100});
            send_fli(4'b0001);
        join
        repeat (10) @(posedge clk);
        #1;
        check("ldrop_ro_none", 128'(ro_hs - snap_ro), 128'(0));
        check("ldrop_tx_none", 128'(tx_hs - snap_tx), 128'(0));

        // arbitration between continuous ring and local 2-word packets
`ifdef PORT_RING_TAP_RING_PRIO_EN
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 2; i++) exp_ro.push_back({4'b0100, pcode_of(i, 2), 64'h5000 + 64'(16 * k + i)});
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 2; i++) exp_ro.push_back({4'b0100, pcode_of(i, 2), 64'h6000 + 64'(16 * k + i)});
`else
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 2; i++) exp_ro.push_back({4'b0100, pcode_of(i, 2), 64'h5000 + 64'(16 * k + i)});
            for (int i = 0; i < 2; i++) exp_ro.push_back({4'b0100, pcode_of(i, 2), 64'h6000 + 64'(16 * k + i)});
        end
`endif
        fork
            for (int k = 0; k < 3; k++) send_ri_pkt(4'b0100, 2, 64'h5000 + 64'(16 * k), 1'b0);
            begin
                @(posedge clk);
                #1;
                for (int k = 0; k < 3; k++) send_px_pkt(2, 64'h6000 + 64'(16 * k));
            end
            for (int k = 0; k < 3; k++) send_fli(4'b0100);
        join
        drain();

        // malformed words in IDLE
        snap_drop = drop_cnt;
        send_px({2'b00, 64'h7000});
        repeat (6) @(posedge clk);
        #1;
        check("px_mid_drop", 128'(drop_cnt - snap_drop), 128'(1));
        snap_drop = drop_cnt;
        snap_ro = ro_hs;
        send_ri({4'b0100, 2'b10, 64'h7100});
        repeat (6) @(posedge clk);
        #1;
        check("ri_eop_drop", 128'(drop_cnt - snap_drop), 128'(1));
        check("ri_eop_no_ro", 128'(ro_hs - snap_ro), 128'(0));

        // asynchronous reset mid-packet
        ro_drdy = 1'b0;
        send_ri({4'b0100, 2'b01, 64'h8000});
        send_ri({4'b0100, 2'b00, 64'h8001});
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("pre_rst_ro_srdy", 128'(ro_srdy), 128'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_srdy", 128'({ro_srdy, ptx_srdy}), 128'(0));
        check("async_rst_drdy", 128'({ri_drdy, prx_drdy, fli_drdy}), 128'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        ro_drdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send_ri_pkt(4'b0110, 1, 64'h9000, 1'b1);
        drain();

        check("sb_empty", 128'(exp_ro.size() + exp_tx.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
